branch_history_queue: RTL and testbench

//  In-order queue holding the global-history snapshot taken at every predicted branch.

---
 rtl/branch_history_queue_if.sv | 38 +++
 rtl/branch_history_queue.sv | 150 +++++++++++++++
 tb/tb_branch_history_queue.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_history_queue_if.sv
// Interface bundling the push, resolve and rollback signals of the branch
// history queue. The master side (fetch/resolve logic) drives pushes and
// resolves; the slave side (the queue) returns status and the rollback history.
interface branch_history_queue_if #(
    parameter int OBQ_DEPTH = 8,
    parameter int GHT_BIT   = 4,
    parameter int TAG_W     = 4
);
    localparam int CNT_W = $clog2(OBQ_DEPTH) + 1;

    logic               enq_en;
    logic [GHT_BIT-1:0] enq_gh;
    logic [TAG_W-1:0]   enq_tag;
    logic               enq_ready;
    logic               resolve_en;
    logic [TAG_W-1:0]   resolve_tag;
    logic               resolve_mispredict;
    logic               clear_en;
    logic               obq_bh_pred_valid;
    logic [GHT_BIT-1:0] obq_gh_out;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               err_tag;
    logic               err_ovf;

    modport master (
        output enq_en, enq_gh, enq_tag, resolve_en, resolve_tag, resolve_mispredict,
        input  enq_ready, clear_en, obq_bh_pred_valid, obq_gh_out, count, full, empty,
               err_tag, err_ovf
    );

    modport slave (
        input  enq_en, enq_gh, enq_tag, resolve_en, resolve_tag, resolve_mispredict,
        output enq_ready, clear_en, obq_bh_pred_valid, obq_gh_out, count, full, empty,
               err_tag, err_ovf
    );
endinterface

// File: rtl/branch_history_queue.sv
// In-order queue of global-history snapshots, one per predicted branch.
// Branches resolve at the head; a mispredict flushes the whole queue and
// emits the head's history with a one-cycle clear pulse to the predictor.
// Optional feature: define BHQ_PERF_EN to add saturating resolve/mispredict
// counters on perf_resolved / perf_mispred.
module branch_history_queue #(
    parameter int OBQ_DEPTH = 8,
    parameter int GHT_BIT   = 4,
    parameter int TAG_W     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    branch_history_queue_if.slave bus
`ifdef BHQ_PERF_EN
    ,
    output logic [15:0]           perf_resolved,
    output logic [15:0]           perf_mispred
`endif
);
    localparam int PTR_W = $clog2(OBQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [GHT_BIT-1:0] ghMem  [OBQ_DEPTH];
    logic [TAG_W-1:0]   tagMem [OBQ_DEPTH];

    ptr_t               head_q, head_d;
    ptr_t               tail_q, tail_d;
    cnt_t               count_q, count_d;
    logic               clear_q, clear_d;
    logic [GHT_BIT-1:0] ghOut_q, ghOut_d;
    logic               errTag_q, errTag_d;
    logic               errOvf_q, errOvf_d;

    logic isFull;
    logic isEmpty;
    logic resolveLegal;
    logic mispredict;
    logic resolveOk;
    logic pushLegal;

    // Decode this cycle's legal operations and compute next pointer/flag state.
    always_comb begin
        isFull       = (count_q == cnt_t'(OBQ_DEPTH));
        isEmpty      = (count_q == '0);
        resolveLegal = bus.resolve_en & ~isEmpty;
        mispredict   = resolveLegal & bus.resolve_mispredict;
        resolveOk    = resolveLegal & ~bus.resolve_mispredict;
        pushLegal    = bus.enq_en & ~isFull & ~mispredict;

        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        clear_d  = 1'b0;
        ghOut_d  = ghOut_q;
        errTag_d = errTag_q;
        errOvf_d = errOvf_q;

        if (resolveLegal && (bus.resolve_tag != tagMem[head_q])) begin
            errTag_d = 1'b1;
        end
        if ((bus.enq_en && isFull && !mispredict) || (bus.resolve_en && isEmpty)) begin
            errOvf_d = 1'b1;
        end

        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            clear_d = 1'b1;
            ghOut_d = ghMem[head_q];
        end else begin
            if (pushLegal) begin
                tail_d = tail_q + ptr_t'(1);
            end
            if (resolveOk) begin
                head_d = head_q + ptr_t'(1);
            end
            if (pushLegal && !resolveOk) begin
                count_d = count_q + cnt_t'(1);
            end else if (!pushLegal && resolveOk) begin
                count_d = count_q - cnt_t'(1);
            end
        end
    end

    // Control state: pointers, occupancy, rollback pulse/history and sticky errors.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            clear_q  <= 1'b0;
            ghOut_q  <= '0;
            errTag_q <= 1'b0;
            errOvf_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            clear_q  <= clear_d;
            ghOut_q  <= ghOut_d;
            errTag_q <= errTag_d;
            errOvf_q <= errOvf_d;
        end
    end

    // Entry storage is written on legal pushes only and is deliberately not reset.
    always_ff @(posedge clock) begin
        if (pushLegal) begin
            ghMem[tail_q]  <= bus.enq_gh;
            tagMem[tail_q] <= bus.enq_tag;
        end
    end

    assign bus.enq_ready         = ~isFull;
    assign bus.full              = isFull;
    assign bus.empty             = isEmpty;
    assign bus.count             = count_q;
    assign bus.clear_en          = clear_q;
    assign bus.obq_bh_pred_valid = clear_q;
    assign bus.obq_gh_out        = ghOut_q;
    assign bus.err_tag           = errTag_q;
    assign bus.err_ovf           = errOvf_q;

`ifdef BHQ_PERF_EN
    logic [15:0] perfResolved_q;
    logic [15:0] perfMispred_q;

    // Saturating counters of legal resolves and legal mispredicts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perfResolved_q <= '0;
            perfMispred_q  <= '0;
        end else begin
            if (resolveLegal && (perfResolved_q != 16'hFFFF)) begin
                perfResolved_q <= perfResolved_q + 16'd1;
            end
            if (mispredict && (perfMispred_q != 16'hFFFF)) begin
                perfMispred_q <= perfMispred_q + 16'd1;
            end
        end
    end

    assign perf_resolved = perfResolved_q;
    assign perf_mispred  = perfMispred_q;
`endif
endmodule

// File: tb/tb_branch_history_queue.sv
// Self-checking bench for branch_history_queue: directed scenarios followed by
// random push/resolve traffic, compared against a queue-based reference model.
module tb_branch_history_queue;
    localparam int D = 8;
    localparam int G = 4;
    localparam int T = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    branch_history_queue_if #(.OBQ_DEPTH(D), .GHT_BIT(G), .TAG_W(T)) bus ();

`ifdef BHQ_PERF_EN
    logic [15:0] perfResolved;
    logic [15:0] perfMispred;
`endif

    branch_history_queue #(.OBQ_DEPTH(D), .GHT_BIT(G), .TAG_W(T)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef BHQ_PERF_EN
        ,
        .perf_resolved (perfResolved),
        .perf_mispred  (perfMispred)
`endif
    );

    typedef struct {
        logic [G-1:0] gh;
        logic [T-1:0] tag;
    } entry_t;

    entry_t       mq[$];
    logic [G-1:0] mGh;
    logic         mClear;
    logic         mErrTag;
    logic         mErrOvf;
    int           mPerfRes;
    int           mPerfMis;

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mGh      = '0;
        mClear   = 1'b0;
        mErrTag  = 1'b0;
        mErrOvf  = 1'b0;
        mPerfRes = 0;
        mPerfMis = 0;
    endtask

    task automatic modelStep(input logic en, input logic [G-1:0] gh, input logic [T-1:0] tag,
                             input logic ren, input logic [T-1:0] rtag, input logic rmis);
        bit     wasFull  = (mq.size() == D);
        bit     wasEmpty = (mq.size() == 0);
        entry_t e;
        e.gh   = gh;
        e.tag  = tag;
        mClear = 1'b0;
        if (ren && !wasEmpty) begin
            if (rtag != mq[0].tag) mErrTag = 1'b1;
            if (mPerfRes < 65535) mPerfRes++;
            if (rmis) begin
                mGh    = mq[0].gh;
                mClear = 1'b1;
                mq.delete();
                if (mPerfMis < 65535) mPerfMis++;
            end else begin
                void'(mq.pop_front());
                if (en) begin
                    if (wasFull) mErrOvf = 1'b1;
                    else mq.push_back(e);
                end
            end
        end else begin
            if (ren) mErrOvf = 1'b1;
            if (en) begin
                if (wasFull) mErrOvf = 1'b1;
                else mq.push_back(e);
            end
        end
    endtask

    task automatic checkOutput(input string step);
        int n = mq.size();
        check({step, "_count"},  32'(bus.count),             32'(n));
        check({step, "_full"},   32'(bus.full),              32'(n == D));
        check({step, "_empty"},  32'(bus.empty),             32'(n == 0));
        check({step, "_ready"},  32'(bus.enq_ready),         32'(n != D));
        check({step, "_clear"},  32'(bus.clear_en),          32'(mClear));
        check({step, "_valid"},  32'(bus.obq_bh_pred_valid), 32'(mClear));
        check({step, "_ghout"},  32'(bus.obq_gh_out),        32'(mGh));
        check({step, "_errtag"}, 32'(bus.err_tag),           32'(mErrTag));
        check({step, "_errovf"}, 32'(bus.err_ovf),           32'(mErrOvf));
`ifdef BHQ_PERF_EN
        check({step, "_perfres"}, 32'(perfResolved), 32'(mPerfRes));
        check({step, "_perfmis"}, 32'(perfMispred),  32'(mPerfMis));
`endif
    endtask

    task automatic applyStimulus(input string step, input logic en, input logic [G-1:0] gh,
                                 input logic [T-1:0] tag, input logic ren,
                                 input logic [T-1:0] rtag, input logic rmis);
        bus.enq_en             = en;
        bus.enq_gh             = gh;
        bus.enq_tag            = tag;
        bus.resolve_en         = ren;
        bus.resolve_tag        = rtag;
        bus.resolve_mispredict = rmis;
        @(posedge clock);
        modelStep(en, gh, tag, ren, rtag, rmis);
        #1;
        checkOutput(step);
    endtask

    task automatic idle(input string step);
        applyStimulus(step, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic resetDut(input string step);
        bus.enq_en             = 1'b0;
        bus.resolve_en         = 1'b0;
        bus.resolve_mispredict = 1'b0;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput(step);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [T-1:0] rtag;
        modelReset();
        bus.enq_en             = 1'b0;
        bus.enq_gh             = '0;
        bus.enq_tag            = '0;
        bus.resolve_en         = 1'b0;
        bus.resolve_tag        = '0;
        bus.resolve_mispredict = 1'b0;

        // Scenario 1: three pushes and a correct resolve.
        resetDut("t1_rst");
        applyStimulus("t1_p0", 1'b1, 4'h3, 4'd0, 1'b0, '0, 1'b0);
        applyStimulus("t1_p1", 1'b1, 4'h5, 4'd1, 1'b0, '0, 1'b0);
        applyStimulus("t1_p2", 1'b1, 4'h9, 4'd2, 1'b0, '0, 1'b0);
        check("t1_count3", 32'(bus.count), 32'd3);
        applyStimulus("t1_res", 1'b0, '0, '0, 1'b1, 4'd0, 1'b0);
        check("t1_count2", 32'(bus.count), 32'd2);
        check("t1_noclear", 32'(bus.clear_en), 32'd0);

        // Scenario 2: fill, then overflow.
        resetDut("t2_rst");
        for (int i = 0; i < D; i++) begin
            applyStimulus("t2_fill", 1'b1, G'(i), T'(i), 1'b0, '0, 1'b0);
        end
        check("t2_full", 32'(bus.full), 32'd1);
        check("t2_ready", 32'(bus.enq_ready), 32'd0);
        applyStimulus("t2_ovf", 1'b1, 4'hC, 4'd9, 1'b0, '0, 1'b0);
        check("t2_errovf", 32'(bus.err_ovf), 32'd1);
        check("t2_count8", 32'(bus.count), 32'd8);

        // Scenario 3: mispredict at head returns its history.
        resetDut("t3_rst");
        applyStimulus("t3_p0", 1'b1, 4'hA, 4'd4, 1'b0, '0, 1'b0);
        applyStimulus("t3_p1", 1'b1, 4'h6, 4'd5, 1'b0, '0, 1'b0);
        applyStimulus("t3_mis", 1'b0, '0, '0, 1'b1, 4'd4, 1'b1);
        check("t3_clear", 32'(bus.clear_en), 32'd1);
        check("t3_valid", 32'(bus.obq_bh_pred_valid), 32'd1);
        check("t3_gh", 32'(bus.obq_gh_out), 32'hA);
        check("t3_count0", 32'(bus.count), 32'd0);
        idle("t3_after");
        check("t3_clear_drop", 32'(bus.clear_en), 32'd0);
        check("t3_gh_hold", 32'(bus.obq_gh_out), 32'hA);

        // Scenario 4: wrong-path push discarded, refetch push accepted.
        resetDut("t4_rst");
        applyStimulus("t4_p0", 1'b1, 4'h7, 4'd1, 1'b0, '0, 1'b0);
        applyStimulus("t4_mis", 1'b1, 4'hF, 4'd2, 1'b1, 4'd1, 1'b1);
        check("t4_count0", 32'(bus.count), 32'd0);
        check("t4_noovf", 32'(bus.err_ovf), 32'd0);
        applyStimulus("t4_refetch", 1'b1, 4'h2, 4'd3, 1'b0, '0, 1'b0);
        check("t4_count1", 32'(bus.count), 32'd1);

        // Scenario 5: pointer wrap, then a tag mismatch.
        resetDut("t5_rst");
        applyStimulus("t5_pre", 1'b1, 4'h1, 4'd1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus("t5_pair", 1'b1, G'(i + 2), T'(i % 8), 1'b1, mq[0].tag, 1'b0);
        end
        applyStimulus("t5_mis", 1'b0, '0, '0, 1'b1, mq[0].tag, 1'b1);
        check("t5_gh", 32'(bus.obq_gh_out), 32'd5);
        applyStimulus("t5_p2", 1'b1, 4'h8, 4'd2, 1'b0, '0, 1'b0);
        applyStimulus("t5_bad", 1'b0, '0, '0, 1'b1, 4'd7, 1'b0);
        check("t5_errtag", 32'(bus.err_tag), 32'd1);

        // Randomized traffic against the reference model.
        resetDut("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            if (mq.size() > 0 && $urandom_range(0, 9) != 0) rtag = mq[0].tag;
            else rtag = T'($urandom);
            applyStimulus("rnd", $urandom_range(0, 9) < 6, G'($urandom), T'($urandom),
                          $urandom_range(0, 9) < 4, rtag, $urandom_range(0, 9) == 0);
        end

        // Scenario 6: asynchronous reset cancels an in-flight clear pulse.
        resetDut("t6_rst");
        applyStimulus("t6_p0", 1'b1, 4'hB, 4'd3, 1'b0, '0, 1'b0);
        applyStimulus("t6_mis", 1'b0, '0, '0, 1'b1, 4'd3, 1'b1);
        check("t6_clear_hi", 32'(bus.clear_en), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_clear_lo", 32'(bus.clear_en), 32'd0);
        check("t6_count0", 32'(bus.count), 32'd0);
        check("t6_ghout0", 32'(bus.obq_gh_out), 32'd0);
`ifdef BHQ_PERF_EN
        check("t6_perfres0", 32'(perfResolved), 32'd0);
        check("t6_perfmis0", 32'(perfMispred), 32'd0);
`endif
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
